ls163_modn_ctrl: RTL and testbench
==================================

Name: ls163_modn_ctrl

Overview:
- Control sequencer that sits beside one LS74163 4-bit synchronous counter.
- Drives the counter's CLR_L, LD_L, ENT, ENP and parallel-load data D..A, and consumes its QD..QA outputs.
- Turns the free-running counter into a programmable modulo-(16-PRESET) divider that runs for PERIODS wraps, then stops.
- Host side uses a START/BUSY/DONE handshake with a HOLD (pause) input.

Parameters:
PW, 8, width of PERIODS and WRAPS (number of wraps per run)

Ports:
CLK  input  1  system clock, rising edge; the same CLK drives the LS74163
RST_L  input  1  reset, asynchronous, active-low
START  input  1  request a run; sampled only in IDLE
HOLD  input  1  pause counting while high
PRESET  input  4  load value, captured at START acceptance
PERIODS  input  PW  wraps to perform, captured at START acceptance
Q  input  4  counter outputs {QD,QC,QB,QA}
CLR_L  output  1  to counter synchronous clear, active-low
LD_L  output  1  to counter synchronous load, active-low
ENT  output  1  to counter ENT
ENP  output  1  to counter ENP
D  output  4  to counter parallel inputs {D,C,B,A}
BUSY  output  1  high in LOAD and RUN
DONE  output  1  one-cycle completion pulse
WRAPS  output  PW  completed wraps in current/last run

Behaviour:
- States: INIT, IDLE, LOAD, RUN, FIN.
- While RST_L=0:
  - State is forced to INIT immediately, asynchronously.
  - Outputs: CLR_L=0, LD_L=1, ENT=0, ENP=0, D=0, BUSY=0, DONE=0, WRAPS=0.
  - preset_r and periods_r are cleared to 0.
- INIT:
  - CLR_L=0 for exactly one cycle after reset release, so the counter synchronously clears to 0.
  - Then go to IDLE.
- IDLE:
  - CLR_L=1, LD_L=1, ENT=ENP=0; counter is frozen.
  - START=1 at an edge captures PRESET into preset_r and PERIODS into periods_r, and clears WRAPS.
  - If PERIODS==0, go to FIN; no LD_L pulse occurs. Otherwise go to LOAD.
- LOAD:
  - Drive LD_L=0 and D=preset_r for one cycle; the counter loads at the next edge.
  - Go to RUN.
- RUN:
  - ENT=1. ENP=~HOLD.
  - D=preset_r throughout.
  - Terminal condition tc = (Q==4'hF) & ~HOLD.
  - tc and WRAPS+1 < periods_r:
    - LD_L=0 combinationally that cycle (Mealy), so the counter reloads preset_r.
    - WRAPS increments.
  - tc and WRAPS+1 == periods_r:
    - CLR_L=0 instead, so the counter goes to 0.
    - WRAPS increments; go to FIN.
  - HOLD=1: no load, no clear, no WRAPS change. The counter holds because ENP=0, including at Q=15.
- FIN:
  - DONE=1 for one cycle, BUSY=0, ENT=ENP=0.
  - Then go to IDLE.
- Period length: each wrap is 16-preset_r RUN cycles with HOLD low. PRESET=15 gives tc on every RUN cycle.
- Latency: with START sampled at edge e0 and no HOLD, DONE is high in the cycle after edge e(1+PERIODS*(16-PRESET)).
- START outside IDLE is ignored. PRESET and PERIODS changes after capture are ignored.
- WRAPS holds its final value until the next accepted START.
- Reset mid-run: immediate return to reset values, then one INIT cycle. No DONE pulse is issued.
- All outputs are registered or decoded from state, except LD_L, CLR_L and ENP in RUN, which depend on Q and HOLD.

Test Plan:
1. Reset, then PRESET=10, PERIODS=3, START one cycle
   - Q runs 10..15 three times, then 0.
   - LD_L low at the first two Q=15 cycles; CLR_L low at the third.
   - DONE high in the cycle after edge e19; WRAPS=3.
2. PERIODS=0, START
   - DONE high the cycle after e0.
   - LD_L never low; Q stays 0; WRAPS=0.
3. PRESET=12, PERIODS=1, HOLD high for 4 cycles once Q=14
   - Q frozen at 14, ENP=0.
   - DONE delayed by 4 cycles versus the no-HOLD run (e5 -> e9).
   - HOLD asserted at Q=15 → no reload, WRAPS unchanged until release.
4. PRESET=15, PERIODS=2
   - LD_L low in the first RUN cycle, CLR_L low in the second.
   - DONE after e3; WRAPS=2.
5. START pulsed again while BUSY with different PRESET
   - Ignored; sequence and WRAPS unaffected.
   - A new START in IDLE after DONE restarts and clears WRAPS.
6. RST_L pulled low mid-RUN at Q=13
   - Immediately: CLR_L=0, BUSY=0, WRAPS=0, no DONE.
   - After release: Q=0 after the INIT edge, then IDLE.

Source files
------------

// File: rtl/ls163_modn_ctrl_if.sv
// ls163_modn_ctrl_if
// Groups everything that crosses the controller boundary except CLK/RST_L.
//   Host side    : START, HOLD, PRESET, PERIODS -> ; <- BUSY, DONE, WRAPS
//   Counter side : Q -> ; <- CLR_L, LD_L, ENT, ENP, D
//   Debug        : STATE exposes the controller FSM state encoding.
// Modports: slave = the controller, master = whoever drives host and counter.
interface ls163_modn_ctrl_if #(
  parameter int PW = 8
);
  logic          START;
  logic          HOLD;
  logic [3:0]    PRESET;
  logic [PW-1:0] PERIODS;
  logic [3:0]    Q;
  logic          CLR_L;
  logic          LD_L;
  logic          ENT;
  logic          ENP;
  logic [3:0]    D;
  logic          BUSY;
  logic          DONE;
  logic [PW-1:0] WRAPS;
  logic [2:0]    STATE;

  modport slave (
    input  START, HOLD, PRESET, PERIODS, Q,
    output CLR_L, LD_L, ENT, ENP, D, BUSY, DONE, WRAPS, STATE
  );

  modport master (
    output START, HOLD, PRESET, PERIODS, Q,
    input  CLR_L, LD_L, ENT, ENP, D, BUSY, DONE, WRAPS, STATE
  );
endinterface

// File: rtl/ls163_modn_ctrl.sv
// ls163_modn_ctrl
// Sequencer beside an LS74163 4-bit counter (same CLK). Turns it into a
// modulo-(16-PRESET) divider that runs for PERIODS wraps, then stops.
// Ports:
//   CLK    : rising-edge clock shared with the counter
//   RST_L  : asynchronous active-low reset
//   bus    : ls163_modn_ctrl_if.slave (host handshake, counter controls,
//            counter Q feedback, STATE debug)
// Handshake: START is a request sampled only in IDLE (elsewhere ignored);
// acceptance captures PRESET/PERIODS and clears WRAPS. BUSY is high while
// the run is in progress (LOAD, RUN). DONE is a one-cycle pulse at
// completion; WRAPS then holds until the next accepted START. HOLD pauses
// counting at any time during RUN.
module ls163_modn_ctrl #(
  parameter int PW = 8
) (
  input  logic               CLK,
  input  logic               RST_L,
  ls163_modn_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S_IDLE = 3'd1,
    S_LOAD = 3'd2,
    S_RUN  = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    preset_q, preset_d;
  logic [PW-1:0] periods_q, periods_d;
  logic [PW-1:0] wraps_q, wraps_d;

  logic          clr_l, ld_l, ent, enp, busy, done;
  logic          tc;
  logic [PW:0]   wraps_inc;

  always_ff @(posedge CLK or negedge RST_L) begin
    if (!RST_L) begin
      state_q   <= S_INIT;
      preset_q  <= '0;
      periods_q <= '0;
      wraps_q   <= '0;
    end else begin
      state_q   <= state_d;
      preset_q  <= preset_d;
      periods_q <= periods_d;
      wraps_q   <= wraps_d;
    end
  end

  // Extra bit so the "is this the last wrap" compare cannot overflow.
  assign wraps_inc = {1'b0, wraps_q} + {{PW{1'b0}}, 1'b1};
  // Counter terminal count; a held counter never produces a wrap.
  assign tc = (bus.Q == 4'hF) && !bus.HOLD;

  always_comb begin
    state_d   = state_q;
    preset_d  = preset_q;
    periods_d = periods_q;
    wraps_d   = wraps_q;
    clr_l     = 1'b1;
    ld_l      = 1'b1;
    ent       = 1'b0;
    enp       = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state_q)
      S_INIT: begin
        // Clears the counter on the first edge after reset release.
        clr_l   = 1'b0;
        state_d = S_IDLE;
      end

      S_IDLE: begin
        if (bus.START) begin
          preset_d  = bus.PRESET;
          periods_d = bus.PERIODS;
          wraps_d   = '0;
          state_d   = (bus.PERIODS == '0) ? S_FIN : S_LOAD;
        end
      end

      S_LOAD: begin
        busy    = 1'b1;
        ld_l    = 1'b0;
        state_d = S_RUN;
      end

      S_RUN: begin
        busy = 1'b1;
        ent  = 1'b1;
        enp  = !bus.HOLD;
        if (tc) begin
          wraps_d = wraps_inc[PW-1:0];
          if (wraps_inc < {1'b0, periods_q}) begin
            // More wraps to go: reload instead of rolling over to 0.
            ld_l = 1'b0;
          end else begin
            // Final wrap: leave the counter at 0 for the next run.
            clr_l   = 1'b0;
            state_d = S_FIN;
          end
        end
      end

      S_FIN: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  assign bus.CLR_L = clr_l;
  assign bus.LD_L  = ld_l;
  assign bus.ENT   = ent;
  assign bus.ENP   = enp;
  // preset_q resets to 0, so D reads 0 until a run is captured.
  assign bus.D     = preset_q;
  assign bus.BUSY  = busy;
  assign bus.DONE  = done;
  assign bus.WRAPS = wraps_q;
  assign bus.STATE = state_q;

endmodule

// File: tb/tb_ls163_modn_ctrl.sv
// tb_ls163_modn_ctrl
// Bench for ls163_modn_ctrl with a behavioural LS74163 attached to the
// counter side. Each run is predicted arithmetically: after k un-held RUN
// cycles the counter shows PRESET + k mod (16-PRESET) and WRAPS is
// k div (16-PRESET); the run ends when k reaches PERIODS*(16-PRESET).
module tb_ls163_modn_ctrl;
  localparam int PW = 8;

  logic clk;
  logic rst_l;
  logic [3:0] cnt_q = 4'h7;

  int n_tests = 0;
  int n_fail  = 0;

  ls163_modn_ctrl_if #(.PW(PW)) bus ();

  ls163_modn_ctrl #(.PW(PW)) dut (
    .CLK   (clk),
    .RST_L (rst_l),
    .bus   (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- LS74163 model ----------------
  always @(posedge clk) begin
    if (!bus.CLR_L)              cnt_q <= 4'h0;
    else if (!bus.LD_L)          cnt_q <= bus.D;
    else if (bus.ENT && bus.ENP) cnt_q <= cnt_q + 4'h1;
  end
  assign bus.Q = cnt_q;

  // ---------------- checker ----------------
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // ---------------- driver tasks ----------------
  // Present START for one edge (e0); returns at the negedge after e0 with
  // START low and the captured operands scrambled.
  task automatic start_run(input logic [3:0] p, input logic [PW-1:0] n);
    bus.START   = 1'b1;
    bus.PRESET  = p;
    bus.PERIODS = n;
    bus.HOLD    = 1'b0;
    next_cycle();
    bus.START   = 1'b0;
    bus.PRESET  = 4'($urandom_range(0, 15));
    bus.PERIODS = PW'($urandom_range(0, 255));
  endtask

  // One complete run checked cycle by cycle against the arithmetic model.
  // hold_at/hold_len force a HOLD burst when k == hold_at; hold_pct adds
  // random HOLD; poke sends ignored STARTs with other operands while busy.
  task automatic run(input logic [3:0] p, input logic [PW-1:0] n,
                     input int hold_at, input int hold_len,
                     input int hold_pct, input bit poke);
    int len, total, k, held, holds, cycles;
    bit h, last;
    len   = 16 - int'(p);
    total = int'(n) * len;
    start_run(p, n);
    cycles = 1;
    if (n == '0) begin
      #1;
      check_eq("zero_done",  bus.DONE,  1);
      check_eq("zero_busy",  bus.BUSY,  0);
      check_eq("zero_wraps", bus.WRAPS, 0);
      check_eq("zero_ld",    bus.LD_L,  1);
      check_eq("zero_q",     bus.Q,     0);
      next_cycle();
      check_eq("zero_done_off", bus.DONE, 0);
      check_eq("zero_q_after",  bus.Q,    0);
      return;
    end
    // LOAD cycle
    if (poke) bus.START = 1'b1;
    #1;
    check_eq("load_busy",  bus.BUSY,  1);
    check_eq("load_ld",    bus.LD_L,  0);
    check_eq("load_d",     bus.D,     p);
    check_eq("load_wraps", bus.WRAPS, 0);
    check_eq("load_done",  bus.DONE,  0);
    next_cycle();
    k = 0; held = 0; holds = 0;
    while (k < total && cycles < 20000) begin
      cycles++;
      if (k == hold_at && held < hold_len) begin
        h = 1'b1;
        held++;
      end else begin
        h = ($urandom_range(0, 99) < hold_pct);
      end
      bus.HOLD = h;
      if (poke) begin
        bus.START  = $urandom_range(0, 1) == 1;
        bus.PRESET = 4'($urandom_range(0, 15));
      end
      #1;
      last = (k / len) + 1 == int'(n);
      check_eq("run_q",     bus.Q,     32'(int'(p) + k % len));
      check_eq("run_wraps", bus.WRAPS, 32'(k / len));
      check_eq("run_busy",  bus.BUSY,  1);
      check_eq("run_ent",   bus.ENT,   1);
      check_eq("run_enp",   bus.ENP,   !h);
      check_eq("run_d",     bus.D,     p);
      check_eq("run_ld",    bus.LD_L,  !(!h && (k % len == len - 1) && !last));
      check_eq("run_clr",   bus.CLR_L, !(!h && (k % len == len - 1) && last));
      check_eq("run_done",  bus.DONE,  0);
      if (!h) k++;
      else    holds++;
      next_cycle();
    end
    check_eq("run_finished", k, total);
    bus.HOLD  = 1'b0;
    bus.START = 1'b0;
    #1;
    // DONE lands 1 + PERIODS*(16-PRESET) + held cycles after e0
    check_eq("latency",    cycles, 1 + total + holds);
    check_eq("fin_done",   bus.DONE,  1);
    check_eq("fin_busy",   bus.BUSY,  0);
    check_eq("fin_wraps",  bus.WRAPS, n);
    check_eq("fin_q",      bus.Q,     0);
    check_eq("fin_enp",    bus.ENP,   0);
    next_cycle();
    check_eq("idle_done",  bus.DONE,  0);
    check_eq("idle_wraps", bus.WRAPS, n);
    check_eq("idle_q",     bus.Q,     0);
    check_eq("idle_ld",    bus.LD_L,  1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_clr"},   bus.CLR_L, 0);
    check_eq({tag, "_ld"},    bus.LD_L,  1);
    check_eq({tag, "_ent"},   bus.ENT,   0);
    check_eq({tag, "_enp"},   bus.ENP,   0);
    check_eq({tag, "_d"},     bus.D,     0);
    check_eq({tag, "_busy"},  bus.BUSY,  0);
    check_eq({tag, "_done"},  bus.DONE,  0);
    check_eq({tag, "_wraps"}, bus.WRAPS, 0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int guard;
    rst_l       = 1'b0;
    bus.START   = 1'b0;
    bus.HOLD    = 1'b0;
    bus.PRESET  = 4'h0;
    bus.PERIODS = '0;
    @(negedge clk);
    check_reset_outputs("rst");
    @(negedge clk);
    rst_l = 1'b1;
    #1;
    check_eq("init_clr", bus.CLR_L, 0);
    next_cycle();
    check_eq("init_q",    bus.Q,     0);
    check_eq("idle_clr0", bus.CLR_L, 1);
    check_eq("idle_busy0", bus.BUSY, 0);

    // Directed runs
    run(4'd10, 8'd3, -1, 0, 0, 1'b0);   // DONE after e19
    run(4'd7,  8'd0, -1, 0, 0, 1'b0);   // zero periods
    run(4'd12, 8'd1,  2, 4, 0, 1'b0);   // hold at Q=14 for 4 cycles
    run(4'd12, 8'd2,  3, 3, 0, 1'b0);   // hold at Q=15 blocks reload
    run(4'd15, 8'd2, -1, 0, 0, 1'b0);   // tc every RUN cycle
    run(4'd10, 8'd2, -1, 0, 0, 1'b1);   // STARTs while busy are ignored
    run(4'd0,  8'd1, -1, 0, 0, 1'b0);   // full 16-cycle wrap

    // Random runs
    for (int i = 0; i < 10; i++) begin
      run(4'($urandom_range(0, 15)), PW'($urandom_range(0, 5)),
          -1, 0, 20, $urandom_range(0, 1) == 1);
    end

    // Reset mid-run at Q=13
    start_run(4'd8, 8'd2);
    guard = 0;
    while (bus.Q != 4'd13 && guard < 40) begin
      next_cycle();
      guard++;
    end
    check_eq("midrst_reach13", guard < 40, 1);
    check_eq("midrst_busy_before", bus.BUSY, 1);
    rst_l = 1'b0;
    #1;
    check_reset_outputs("midrst");
    next_cycle();
    check_eq("midrst_done_held", bus.DONE, 0);
    rst_l = 1'b1;
    #1;
    check_eq("midrst_init_clr", bus.CLR_L, 0);
    check_eq("midrst_init_done", bus.DONE, 0);
    next_cycle();
    check_eq("midrst_q0",   bus.Q,     0);
    check_eq("midrst_clr",  bus.CLR_L, 1);
    check_eq("midrst_busy", bus.BUSY,  0);
    check_eq("midrst_done", bus.DONE,  0);

    // Controller must be usable again after the mid-run reset
    run(4'd13, 8'd2, -1, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
